weight_bram_load_ctrl: RTL

Write-side sequencer for the weight BRAM bank array. It accepts a single stream of weight words over a valid/ready handshake and scatters them round-robin across the NUM_BRAMS banks, starting at a programmable base address. Its per-bank write enables, write addresses and write data drive the flat write interface of the weight BRAM subsystem directly. It reports completion and framing errors to the layer controller.

---
 rtl/weight_bram_load_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/weight_bram_load_ctrl.sv
// weight_bram_load_ctrl: scatters a weight stream round-robin across the BRAM banks from a base address.
module weight_bram_load_ctrl #(
    parameter int DW         = 16,
    parameter int NUM_BRAMS  = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            num_words,
    input  logic                           s_valid,
    input  logic signed [DW-1:0]           s_data,
    input  logic                           s_last,
    output logic                           s_ready,
    output logic [NUM_BRAMS-1:0]           w_we,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0] w_addr_wr_flat,
    output logic signed [NUM_BRAMS*DW-1:0] w_din_flat,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);
    localparam int BW = $clog2(NUM_BRAMS);
    localparam int CW = $clog2(DEPTH) + BW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                          r_state, w_next;
    logic [ADDR_WIDTH-1:0]           r_base;
    logic [ADDR_WIDTH:0]             r_num;
    logic [CW-1:0]                   r_cnt;
    logic                            r_err;
    logic [NUM_BRAMS-1:0]            r_we;
    logic [NUM_BRAMS*ADDR_WIDTH-1:0] r_addr;
    logic [NUM_BRAMS*DW-1:0]         r_din;
    logic                            w_acc, w_final, w_end;
    logic [BW-1:0]                   w_bank;
    logic [ADDR_WIDTH-1:0]           w_addr;

    // beat k lands in bank k mod NUM_BRAMS at row base + k/NUM_BRAMS, wrapping at DEPTH
    assign w_acc   = s_valid && (r_state == LOAD);
    assign w_final = r_cnt == (CW'(r_num) << BW) - CW'(1);
    assign w_end   = w_acc && (s_last || w_final);
    assign w_bank  = r_cnt[BW-1:0];
    assign w_addr  = r_base + r_cnt[BW +: ADDR_WIDTH];

    always_comb begin
        w_next = (r_state == IDLE) ? (start ? ((num_words == '0) ? DONE : LOAD) : IDLE) :
                 (r_state == LOAD) ? (w_end ? DONE : LOAD) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_num   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_we    <= '0;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= w_acc ? (NUM_BRAMS'(1) << w_bank) : '0;
            if (r_state == IDLE && start) begin
                r_base <= base_addr;
                r_num  <= num_words;
                r_cnt  <= '0;
                r_err  <= 1'b0;
            end
            if (w_acc) begin
                r_cnt <= r_cnt + CW'(1);
                // s_last must coincide exactly with the expected final beat
                if (s_last != w_final) r_err <= 1'b1;
                for (int i = 0; i < NUM_BRAMS; i++) begin
                    if (w_bank == BW'(i)) begin
                        r_addr[i*ADDR_WIDTH +: ADDR_WIDTH] <= w_addr;
                        r_din[i*DW +: DW]                  <= s_data;
                    end
                end
            end
        end
    end

    assign s_ready        = r_state == LOAD;
    assign busy           = r_state != IDLE;
    assign done           = r_state == DONE;
    assign error          = r_err;
    assign w_we           = r_we;
    assign w_addr_wr_flat = r_addr;
    assign w_din_flat     = r_din;
endmodule
